// File: rtl/mac_array_3x3.sv
// mac_array_3x3
// Compute stage behind the 3x3 operand memory bank. Nine unsigned MAC cells
// build C[i][j] = sum_k W[i][k]*X[k][j] from the three W-lane and three X-lane
// operands presented each cycle. When the bank raises unload_res, the cells
// freeze and the C elements inside rows x cols stream out in row-major order
// over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   data_outw1..3                W lane i (lanes 1..3 -> i = 0..2), 4 bits
//   data_outx1..3                X lane j (lanes 1..3 -> j = 0..2), 4 bits
//   ld_mac, clear_mac            per-cell accumulate / clear, cell = 3*i + j
//   unload_res                   bank finished presenting all k steps
//   row_w, col_x                 number of C rows / columns to emit (0..3)
//   res_data, res_row, res_col   current result beat and its index
//   res_valid, res_ready         output handshake
//   res_last                     final beat of the job
//   busy                         high while draining
//   job_done                     one-cycle pulse after the drain completes
module mac_array_3x3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_outw1,
    input  logic [3:0] data_outw2,
    input  logic [3:0] data_outw3,
    input  logic [3:0] data_outx1,
    input  logic [3:0] data_outx2,
    input  logic [3:0] data_outx3,
    input  logic [8:0] ld_mac,
    input  logic [8:0] clear_mac,
    input  logic       unload_res,
    input  logic [1:0] row_w,
    input  logic [1:0] col_x,
    output logic [9:0] res_data,
    output logic [1:0] res_row,
    output logic [1:0] res_col,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_last,
    output logic       busy,
    output logic       job_done
);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] acc_q [9];
    logic [9:0] acc_d [9];
    logic [1:0] rows_q, rows_d;
    logic [1:0] cols_q, cols_d;
    logic [9:0] res_data_q, res_data_d;
    logic [1:0] res_row_q, res_row_d;
    logic [1:0] res_col_q, res_col_d;
    logic       res_valid_q, res_valid_d;
    logic       res_last_q, res_last_d;
    logic       busy_q, busy_d;
    logic       job_done_q, job_done_d;

    logic [3:0] w_lane [3];
    logic [3:0] x_lane [3];
    logic [7:0] prod [3][3];

    // Beat to present next; the output row/col registers double as the
    // drain read pointer.
    logic       load_beat;
    logic       finish_job;
    logic [1:0] beat_r, beat_c;
    logic [1:0] beat_rows, beat_cols;
    logic [3:0] beat_idx;

    assign w_lane[0] = data_outw1;
    assign w_lane[1] = data_outw2;
    assign w_lane[2] = data_outw3;
    assign x_lane[0] = data_outx1;
    assign x_lane[1] = data_outx2;
    assign x_lane[2] = data_outx3;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                prod[i][j] = {4'b0000, w_lane[i]} * {4'b0000, x_lane[j]};
            end
        end
    end

    // Cells only move in ACCUM, and not in the cycle unload_res is seen,
    // so the first drained beat always reflects the frozen sums.
    always_comb begin
        for (int c = 0; c < 9; c++) begin
            acc_d[c] = acc_q[c];
        end
        if (state_q == ST_ACCUM && !unload_res) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    if (clear_mac[3*i+j]) begin
                        acc_d[3*i+j] = '0;
                    end else if (ld_mac[3*i+j]) begin
                        acc_d[3*i+j] = acc_q[3*i+j] + {2'b00, prod[i][j]};
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        res_data_d  = res_data_q;
        res_row_d   = res_row_q;
        res_col_d   = res_col_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        busy_d      = busy_q;
        job_done_d  = 1'b0;
        load_beat   = 1'b0;
        finish_job  = 1'b0;
        beat_r      = '0;
        beat_c      = '0;
        beat_rows   = rows_q;
        beat_cols   = cols_q;

        case (state_q)
            ST_ACCUM: begin
                if (unload_res) begin
                    state_d   = ST_DRAIN;
                    rows_d    = row_w;
                    cols_d    = col_x;
                    busy_d    = 1'b1;
                    beat_rows = row_w;
                    beat_cols = col_x;
                    // An empty job issues no beats at all.
                    load_beat = (row_w != 2'd0) && (col_x != 2'd0);
                end
            end
            ST_DRAIN: begin
                if (!res_valid_q) begin
                    finish_job = 1'b1;
                end else if (res_ready) begin
                    if (res_last_q) begin
                        finish_job = 1'b1;
                    end else begin
                        load_beat = 1'b1;
                        if (res_col_q == cols_q - 2'd1) begin
                            beat_r = res_row_q + 2'd1;
                            beat_c = 2'd0;
                        end else begin
                            beat_r = res_row_q;
                            beat_c = res_col_q + 2'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                // Wait for unload_res to drop so a held-high level never
                // starts a second drain.
                if (!unload_res) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        beat_idx = ({2'b00, beat_r} * 4'd3) + {2'b00, beat_c};

        if (load_beat) begin
            res_valid_d = 1'b1;
            res_data_d  = acc_q[beat_idx];
            res_row_d   = beat_r;
            res_col_d   = beat_c;
            res_last_d  = (beat_r == beat_rows - 2'd1) && (beat_c == beat_cols - 2'd1);
        end

        if (finish_job) begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            job_done_d  = 1'b1;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            res_data_d  = '0;
            res_row_d   = '0;
            res_col_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            for (int c = 0; c < 9; c++) begin
                acc_q[c] <= '0;
            end
            rows_q      <= '0;
            cols_q      <= '0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            job_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int c = 0; c < 9; c++) begin
                acc_q[c] <= acc_d[c];
            end
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            res_data_q  <= res_data_d;
            res_row_q   <= res_row_d;
            res_col_q   <= res_col_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
            job_done_q  <= job_done_d;
        end
    end

    assign res_data  = res_data_q;
    assign res_row   = res_row_q;
    assign res_col   = res_col_q;
    assign res_valid = res_valid_q;
    assign res_last  = res_last_q;
    assign busy      = busy_q;
    assign job_done  = job_done_q;

endmodule

// File: tb/tb_mac_array_3x3.sv
// tb_mac_array_3x3
// Self-checking bench for mac_array_3x3. A beat-level model (accumulator
// array plus a queue of expected beats) is compared against the DUT on every
// falling edge; directed jobs add hand-computed literal expectations.
module tb_mac_array_3x3;

    logic       clk;
    logic       rst_n;
    logic [3:0] data_outw1, data_outw2, data_outw3;
    logic [3:0] data_outx1, data_outx2, data_outx3;
    logic [8:0] ld_mac;
    logic [8:0] clear_mac;
    logic       unload_res;
    logic [1:0] row_w;
    logic [1:0] col_x;
    logic [9:0] res_data;
    logic [1:0] res_row;
    logic [1:0] res_col;
    logic       res_valid;
    logic       res_ready;
    logic       res_last;
    logic       busy;
    logic       job_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int data;
        int row;
        int col;
    } beat_t;

    int    m_acc [9];
    beat_t m_q [$];
    int    m_mode;
    bit    m_job_done;
    int    beat_log [$];

    mac_array_3x3 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_outw1 (data_outw1),
        .data_outw2 (data_outw2),
        .data_outw3 (data_outw3),
        .data_outx1 (data_outx1),
        .data_outx2 (data_outx2),
        .data_outx3 (data_outx3),
        .ld_mac     (ld_mac),
        .clear_mac  (clear_mac),
        .unload_res (unload_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .res_data   (res_data),
        .res_row    (res_row),
        .res_col    (res_col),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_last   (res_last),
        .busy       (busy),
        .job_done   (job_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: mode 0 = accumulating, 1 = draining, 2 = waiting for unload to drop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 9; c++) m_acc[c] = 0;
            m_q.delete();
            m_mode     = 0;
            m_job_done = 0;
        end else begin
            int w [3];
            int x [3];
            w[0] = data_outw1; w[1] = data_outw2; w[2] = data_outw3;
            x[0] = data_outx1; x[1] = data_outx2; x[2] = data_outx3;
            m_job_done = 0;
            case (m_mode)
                0: begin
                    if (unload_res) begin
                        for (int r = 0; r < row_w; r++) begin
                            for (int c = 0; c < col_x; c++) begin
                                beat_t b;
                                b.data = m_acc[3*r+c];
                                b.row  = r;
                                b.col  = c;
                                m_q.push_back(b);
                            end
                        end
                        m_mode = 1;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            for (int j = 0; j < 3; j++) begin
                                if (clear_mac[3*i+j]) m_acc[3*i+j] = 0;
                                else if (ld_mac[3*i+j]) m_acc[3*i+j] = m_acc[3*i+j] + w[i] * x[j];
                            end
                        end
                    end
                end
                1: begin
                    if (m_q.size() == 0) begin
                        m_mode     = 2;
                        m_job_done = 1;
                    end else if (res_ready) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) begin
                            m_mode     = 2;
                            m_job_done = 1;
                        end
                    end
                end
                default: begin
                    if (!unload_res) m_mode = 0;
                end
            endcase
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_valid;
            exp_valid = (m_mode == 1) && (m_q.size() > 0);
            checkOutput("res_valid", int'(res_valid), int'(exp_valid));
            checkOutput("busy", int'(busy), (m_mode == 1) ? 1 : 0);
            checkOutput("job_done", int'(job_done), int'(m_job_done));
            if (exp_valid && res_valid) begin
                checkOutput("res_data", int'(res_data), m_q[0].data);
                checkOutput("res_row", int'(res_row), m_q[0].row);
                checkOutput("res_col", int'(res_col), m_q[0].col);
                checkOutput("res_last", int'(res_last), (m_q.size() == 1) ? 1 : 0);
            end
            if (res_valid && res_ready) beat_log.push_back(int'(res_data));
        end
    end

    task automatic applyStimulus(input int w1, input int w2, input int w3,
                                 input int x1, input int x2, input int x3,
                                 input logic [8:0] ld, input logic [8:0] clr);
        data_outw1 = 4'(w1); data_outw2 = 4'(w2); data_outw3 = 4'(w3);
        data_outx1 = 4'(x1); data_outx2 = 4'(x2); data_outx3 = 4'(x3);
        ld_mac     = ld;
        clear_mac  = clr;
        @(posedge clk);
        #1;
    endtask

    // Runs one job: raise unload, drain with the chosen ready pattern,
    // linger in DONE, then drop unload. noisy drives clears/loads while draining.
    task automatic runDrain(input int rows, input int cols, input int ready_mode, input bit noisy);
        bit seen;
        seen = 0;
        beat_log.delete();
        data_outw1 = 0; data_outw2 = 0; data_outw3 = 0;
        data_outx1 = 0; data_outx2 = 0; data_outx3 = 0;
        ld_mac = '0; clear_mac = '0;
        row_w = 2'(rows);
        col_x = 2'(cols);
        unload_res = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            res_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (noisy && cyc > 0) begin
                clear_mac  = 9'h1FF;
                ld_mac     = ((cyc % 2) == 1) ? 9'h1FF : 9'h000;
                data_outw1 = 15; data_outw2 = 15; data_outw3 = 15;
                data_outx1 = 15; data_outx2 = 15; data_outx3 = 15;
            end
            @(posedge clk);
            #1;
            if (job_done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("job_done_within_bound", int'(seen), 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        unload_res = 1'b0;
        res_ready  = 1'b0;
        ld_mac = '0; clear_mac = '0;
        data_outw1 = 0; data_outw2 = 0; data_outw3 = 0;
        data_outx1 = 0; data_outx2 = 0; data_outx3 = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_res_data"}, int'(res_data), 0);
        checkOutput({tag, "_res_row"}, int'(res_row), 0);
        checkOutput({tag, "_res_col"}, int'(res_col), 0);
        checkOutput({tag, "_res_valid"}, int'(res_valid), 0);
        checkOutput({tag, "_res_last"}, int'(res_last), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_job_done"}, int'(job_done), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        data_outw1 = 0; data_outw2 = 0; data_outw3 = 0;
        data_outx1 = 0; data_outx2 = 0; data_outx3 = 0;
        ld_mac = '0; clear_mac = '0;
        unload_res = 1'b0; row_w = '0; col_x = '0; res_ready = 1'b0;
        #2;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] identity W times X = 1..9");
        applyStimulus(0, 0, 0, 0, 0, 0, 9'h000, 9'h1FF);
        applyStimulus(1, 0, 0, 1, 2, 3, 9'h1FF, 9'h000);
        applyStimulus(0, 1, 0, 4, 5, 6, 9'h1FF, 9'h000);
        applyStimulus(0, 0, 1, 7, 8, 9, 9'h1FF, 9'h000);
        runDrain(3, 3, 0, 0);
        checkOutput("ident_beats", beat_log.size(), 9);
        checkOutput("ident_first", beat_log[0], 1);
        checkOutput("ident_last", beat_log[8], 9);
        checkOutput("ident_model_centre", m_acc[4], 5);

        $display("[TB] all operands 15");
        applyStimulus(0, 0, 0, 0, 0, 0, 9'h000, 9'h1FF);
        for (int k = 0; k < 3; k++) applyStimulus(15, 15, 15, 15, 15, 15, 9'h1FF, 9'h000);
        runDrain(3, 3, 0, 0);
        checkOutput("max_first", beat_log[0], 675);
        checkOutput("max_last", beat_log[8], 675);
        checkOutput("max_model", m_acc[8], 675);

        $display("[TB] 2x3 job with stalls");
        applyStimulus(0, 0, 0, 0, 0, 0, 9'h000, 9'h1FF);
        applyStimulus(1, 2, 3, 4, 5, 6, 9'h1FF, 9'h000);
        applyStimulus(1, 2, 3, 4, 5, 6, 9'h1FF, 9'h000);
        runDrain(2, 3, 1, 0);
        checkOutput("r2x3_beats", beat_log.size(), 6);
        checkOutput("r2x3_first", beat_log[0], 8);
        checkOutput("r2x3_last", beat_log[5], 24);
        runDrain(3, 3, 0, 0);
        checkOutput("row2_col0_intact", beat_log[6], 24);
        checkOutput("row2_col2_intact", beat_log[8], 36);

        $display("[TB] empty job");
        runDrain(0, 3, 0, 0);
        checkOutput("empty_beats", beat_log.size(), 0);

        $display("[TB] clear and load during drain");
        runDrain(3, 3, 0, 1);
        checkOutput("noisy_first", beat_log[0], 8);
        checkOutput("noisy_last", beat_log[8], 36);
        applyStimulus(0, 0, 0, 0, 0, 0, 9'h000, 9'h1FF);
        runDrain(3, 3, 0, 0);
        checkOutput("cleared_beats", beat_log.size(), 9);
        checkOutput("cleared_first", beat_log[0], 0);
        checkOutput("cleared_last", beat_log[8], 0);

        $display("[TB] reset during drain");
        applyStimulus(2, 2, 2, 3, 3, 3, 9'h1FF, 9'h000);
        applyStimulus(0, 0, 0, 0, 0, 0, 9'h000, 9'h000);
        row_w = 2'd3; col_x = 2'd3; res_ready = 1'b1; unload_res = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_reset_row", int'(res_row), 1);
        checkOutput("pre_reset_col", int'(res_col), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        unload_res = 1'b0;
        res_ready = 1'b0;
        applyStimulus(1, 1, 1, 1, 2, 3, 9'h1FF, 9'h000);
        runDrain(3, 3, 0, 0);
        checkOutput("post_reset_beats", beat_log.size(), 9);
        checkOutput("post_reset_first", beat_log[0], 1);
        checkOutput("post_reset_centre", beat_log[4], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
